// File: rtl/rf_read_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter_pkg
//   Shared definitions for the register-file read-port arbiter: default data
//   and index widths, FSM state encoding, and a helper that sizes requester
//   index fields.
// -----------------------------------------------------------------------------
package rf_read_port_arbiter_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 5;

  // Encodings are shared with the register file and control unit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Width of a requester index; at least one bit so NREQ=1 still has a field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_read_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter_rr_pick
//   Combinational round-robin picker. Scans req_i starting at ptr_i and
//   wrapping modulo N; the first set bit wins.
// Ports:
//   req_i  [N]   request bits
//   ptr_i  [IW]  first index to consider (must be < N)
//   gnt_o  [N]   one-hot grant (all zero when no request)
//   idx_o  [IW]  index of the granted bit (0 when no request)
//   any_o        at least one request present
// -----------------------------------------------------------------------------
module rf_read_port_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] pos_s;

  // Rotating priority scan; one spare bit in pos_s absorbs the wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos_s = '0;
    for (int k = 0; k < N; k++) begin
      pos_s = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos_s >= (IW+1)'(N)) begin
        pos_s = pos_s - (IW+1)'(N);
      end else begin
        pos_s = pos_s;
      end
      if (!any_o && req_i[pos_s[IW-1:0]]) begin
        any_o                  = 1'b1;
        gnt_o[pos_s[IW-1:0]]   = 1'b1;
        idx_o                  = pos_s[IW-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/rf_read_port_arbiter.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter
//   Shares the register file's single read mux among NREQ requesters with a
//   round-robin grant and a valid/ready handshake on both request and
//   response sides. The select and response data are registered; the
//   response is held until its owner accepts it.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid [NREQ]      request pending per requester
//   req_addr  [NREQ*AW]   register index, requester i at [i*AW +: AW]
//   req_ready [NREQ]      one-hot, combinational: request accepted this cycle
//   mux_sel   [AW]        registered read mux select
//   mux_y     [XLEN]      read mux output
//   rsp_valid [NREQ]      one-hot: response available for requester i
//   rsp_data  [XLEN]      shared response data
//   rsp_ready [NREQ]      requester accepts its response
// -----------------------------------------------------------------------------
module rf_read_port_arbiter
  import rf_read_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int XLEN    = XLEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_X0 = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      mux_sel,
  input  logic [XLEN-1:0]        mux_y,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [XLEN-1:0]        rsp_data,
  input  logic [NREQ-1:0]        rsp_ready
);

  localparam int IW = idx_w(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     id_q;
  logic [ADDR_W-1:0] sel_q;
  logic [XLEN-1:0]   data_q;

  logic [NREQ-1:0]   gnt_s;
  logic [IW-1:0]     gnt_idx_s;
  logic              any_s;
  logic              accept_s;

  rf_read_port_arbiter_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (any_s)
  );

  // Next-state and accept decision; RESP can hand off directly to a new
  // request in the same cycle its owner takes the response.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          accept_s = 1'b1;
          state_d  = ST_ADDR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ADDR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[id_q]) begin
          if (any_s) begin
            accept_s = 1'b1;
            state_d  = ST_ADDR;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Pointer moves just past the winner; with NREQ=1 it wraps to 0 at once.
    if (accept_s) begin
      rr_d = (gnt_idx_s == IW'(NREQ-1)) ? '0 : gnt_idx_s + IW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // State, pointer and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (accept_s) begin
        sel_q <= req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
        id_q  <= gnt_idx_s;
      end else begin
        sel_q <= sel_q;
        id_q  <= id_q;
      end
      // Mux has seen a stable select for a full cycle by now.
      if (state_q == ST_ADDR) begin
        data_q <= ((ZERO_X0 != 0) && (sel_q == '0)) ? '0 : mux_y;
      end else begin
        data_q <= data_q;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    req_ready = accept_s ? gnt_s : '0;
    rsp_valid = '0;
    if (state_q == ST_RESP) begin
      rsp_valid[id_q] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  assign mux_sel  = sel_q;
  assign rsp_data = data_q;

endmodule
